mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_if_pkg.sv | 7 +
 rtl/load_extend.sv | 12 +
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared defaults and FSM state type for the memory access unit
package mem_if_pkg;
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int ADDRESS_WIDTH_DEF = 20;
    localparam int MEM_SIZE_DEF      = 8192;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: byte/word load result formatting
// Ports: data (raw memory word), is_byte (byte access), is_signed (sign-extend byte), result (formatted word)
module load_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  is_byte,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] result
);
    assign result = is_byte ? {{(DATA_WIDTH-8){is_signed & data[7]}}, data[7:0]} : data;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between a pipeline and a word memory
// Ports: clk/rst; pipeline request (req_*) and response (resp_*) handshakes plus busy;
//        memory side mem_address/mem_write_data/mem_we/mem_re/mem_be driven only in ACCESS, mem_read_data in
module mem_access_unit
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int MEM_SIZE      = MEM_SIZE_DEF,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_byte,
    input  logic                     req_signed,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);
    localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE * 4);
    state_t                   state, state_n;
    logic [2:0]               cnt;
    logic                     r_write, r_byte, r_signed;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, rdata, ext;
    logic                     err, illegal, accept, in_access;
    assign illegal   = (!req_byte && req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= LIMIT);
    assign accept    = state == IDLE && req_valid;
    assign in_access = state == ACCESS;
    assign req_ready      = state == IDLE;
    assign busy           = state != IDLE;
    assign resp_valid     = state == RESP;
    assign resp_rdata     = rdata;
    assign resp_err       = err;
    assign mem_address    = in_access ? r_addr : '0;
    assign mem_write_data = in_access ? r_wdata : '0;
    assign mem_be         = in_access & r_byte;
    assign mem_we         = in_access & r_write;
    assign mem_re         = in_access & !r_write;
    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .data      (mem_read_data),
        .is_byte   (r_byte),
        .is_signed (r_signed),
        .result    (ext)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? (illegal ? RESP : ACCESS) : IDLE;
            ACCESS:  state_n = (r_write || cnt == 3'd0) ? RESP : ACCESS;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                r_write  <= req_write;
                r_byte   <= req_byte;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_byte ? {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]} : req_wdata;
                cnt      <= 3'(READ_LATENCY - 1);
                rdata    <= '0;
                err      <= illegal;
            end
            // read data is only guaranteed in the final mem_re cycle
            if (in_access && !r_write) begin
                cnt <= cnt == 3'd0 ? cnt : cnt - 3'd1;
                if (cnt == 3'd0)
                    rdata <= ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of two units (READ_LATENCY 1 and 3) against a byte-addressed memory model
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, resp_ready = '0;
    logic [1:0]  req_ready, resp_valid, resp_err, busy, mem_we, mem_re, mem_be;
    logic        req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] resp_rdata [2];
    logic [31:0] mem_write_data [2];
    logic [31:0] mem_read_data [2];
    logic [19:0] mem_address [2];
    logic [7:0]  mem [32772];
    int          re_cnt [2];
    int          re_total [2];
    int          we_total [2];
    logic [19:0] last_wa [2];
    logic [31:0] last_wd [2];
    logic        last_be [2];
    bit          both_seen = 1'b0;
    int          n_checks = 0, n_err = 0;

    mem_access_unit #(.READ_LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0]), .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_be(mem_be[0]), .mem_read_data(mem_read_data[0])
    );
    mem_access_unit #(.READ_LATENCY(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1]), .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_be(mem_be[1]), .mem_read_data(mem_read_data[1])
    );

    // Little-endian byte memory; a byte access uses lane [7:0]
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            re_cnt[i] <= mem_re[i] ? re_cnt[i] + 1 : 0;
            if (mem_re[i]) re_total[i] <= re_total[i] + 1;
            if (mem_we[i] && mem_re[i]) both_seen <= 1'b1;
            if (mem_we[i]) begin
                we_total[i] <= we_total[i] + 1;
                last_wa[i]  <= mem_address[i];
                last_wd[i]  <= mem_write_data[i];
                last_be[i]  <= mem_be[i];
                if (mem_be[i]) mem[int'(mem_address[i][14:0])] <= mem_write_data[i][7:0];
                else for (int k = 0; k < 4; k++) mem[int'(mem_address[i][14:0]) + k] <= mem_write_data[i][8*k +: 8];
            end
        end
    end

    // Data is presented only in the final cycle of the mem_re window; other cycles return a marker
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            int a;
            a = int'(mem_address[i][14:0]);
            mem_read_data[i] = 32'hDEADBEEF;
            if (mem_re[i] && re_cnt[i] == (i == 0 ? 0 : 2))
                mem_read_data[i] = mem_be[i] ? {24'h0, mem[a]} : {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int s, input logic w, input logic b, input logic sg,
                         input logic [19:0] a, input logic [31:0] d);
        req_write = w; req_byte = b; req_signed = sg; req_addr = a; req_wdata = d;
        req_valid[s] = 1'b1;
        check("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(negedge clk);
        req_valid[s] = 1'b0;
    endtask

    task automatic wait_resp(input int s, output int lat);
        lat = 1;
        while (!resp_valid[s] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid[s]) check("resp_timeout", 32'(resp_valid[s]), 32'd1);
    endtask

    task automatic consume(input int s);
        resp_ready[s] = 1'b1;
        @(negedge clk);
        resp_ready[s] = 1'b0;
    endtask

    task automatic xact(input int s, input logic w, input logic b, input logic sg,
                        input logic [19:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nre, output int nwe);
        int r0, w0;
        r0 = re_total[s];
        w0 = we_total[s];
        issue(s, w, b, sg, a, d);
        wait_resp(s, lat);
        rd  = resp_rdata[s];
        er  = resp_err[s];
        nre = re_total[s] - r0;
        nwe = we_total[s] - w0;
        consume(s);
    endtask

    initial begin
        int lat, nre, nwe, r0;
        logic [31:0] rd, held;
        logic er;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd1);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            check("rst_mem_we_re_be", 32'({mem_we[s], mem_re[s], mem_be[s]}), 32'd0);
            check("rst_resp_rdata", resp_rdata[s], 32'd0);
            check("rst_mem_address", 32'(mem_address[s]), 32'd0);
        end
        rst = 1'b0;
        xact(0, 1, 0, 0, 20'h18, 32'hB6A84325, lat, rd, er, nre, nwe);
        check("st_word_lat", lat, 2);
        check("st_word_we", nwe, 1);
        check("st_word_re", nre, 0);
        check("st_word_rdata", rd, 32'd0);
        check("st_word_wd", last_wd[0], 32'hB6A84325);
        check("st_word_be", 32'(last_be[0]), 32'd0);
        xact(0, 1, 0, 0, 20'h7FFC, 32'h11223344, lat, rd, er, nre, nwe);
        check("st_top_err", 32'(er), 32'd0);
        check("st_top_we", nwe, 1);
        xact(0, 0, 0, 0, 20'h18, 32'h0, lat, rd, er, nre, nwe);
        check("ld_word_lat", lat, 2);
        check("ld_word_re", nre, 1);
        check("ld_word_we", nwe, 0);
        check("ld_word_rdata", rd, 32'hB6A84325);
        check("ld_word_err", 32'(er), 32'd0);
        xact(0, 1, 1, 0, 20'h19, 32'hAABBCC74, lat, rd, er, nre, nwe);
        check("st_byte_we", nwe, 1);
        check("st_byte_be", 32'(last_be[0]), 32'd1);
        check("st_byte_addr", 32'(last_wa[0]), 32'h19);
        check("st_byte_data", 32'(last_wd[0][7:0]), 32'h74);
        check("st_byte_rdata", rd, 32'd0);
        xact(0, 0, 1, 1, 20'h19, 32'h0, lat, rd, er, nre, nwe);
        check("ld_sbyte_pos", rd, 32'h00000074);
        check("ld_sbyte_lat", lat, 2);
        xact(0, 1, 1, 0, 20'h19, 32'h000000F4, lat, rd, er, nre, nwe);
        xact(0, 0, 1, 1, 20'h19, 32'h0, lat, rd, er, nre, nwe);
        check("ld_sbyte_neg", rd, 32'hFFFFFFF4);
        xact(0, 0, 1, 0, 20'h19, 32'h0, lat, rd, er, nre, nwe);
        check("ld_ubyte", rd, 32'h000000F4);
        xact(0, 0, 0, 0, 20'h7FFC, 32'h0, lat, rd, er, nre, nwe);
        check("ld_top_word", rd, 32'h11223344);
        check("ld_top_err", 32'(er), 32'd0);
        xact(0, 0, 0, 0, 20'h1A, 32'h0, lat, rd, er, nre, nwe);
        check("mis_err", 32'(er), 32'd1);
        check("mis_lat", lat, 1);
        check("mis_mem", nre + nwe, 0);
        xact(0, 0, 0, 0, 20'h8000, 32'h0, lat, rd, er, nre, nwe);
        check("oob_ld_err", 32'(er), 32'd1);
        check("oob_ld_lat", lat, 1);
        check("oob_ld_mem", nre + nwe, 0);
        xact(0, 1, 1, 0, 20'h8000, 32'h55, lat, rd, er, nre, nwe);
        check("oob_st_err", 32'(er), 32'd1);
        check("oob_st_we", nwe, 0);
        xact(0, 1, 0, 0, 20'h20, 32'hCAFEF00D, lat, rd, er, nre, nwe);
        r0 = re_total[1];
        issue(1, 0, 0, 0, 20'h18, 32'h0);
        wait_resp(1, lat);
        check("rl3_lat", lat, 4);
        check("rl3_re", re_total[1] - r0, 3);
        check("rl3_rdata", resp_rdata[1], 32'hB6A8F425);
        held = resp_rdata[1];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid[1]), 32'd1);
            check("hold_rdata", resp_rdata[1], held);
            check("hold_req_ready", 32'(req_ready[1]), 32'd0);
        end
        req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 20'h20;
        req_valid[1] = 1'b1;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        check("same_cycle_not_taken", 32'(busy[1]), 32'd0);
        check("same_cycle_resp_done", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("next_cycle_taken", 32'(busy[1]), 32'd1);
        wait_resp(1, lat);
        check("late_lat", lat, 4);
        check("late_rdata", resp_rdata[1], 32'hCAFEF00D);
        consume(1);
        r0 = re_total[1];
        issue(1, 0, 0, 0, 20'h18, 32'h0);
        @(negedge clk);
        check("abort_in_access", 32'(mem_re[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_mem_re", 32'(mem_re[1]), 32'd0);
        check("abort_mem_address", 32'(mem_address[1]), 32'd0);
        check("abort_resp_rdata", resp_rdata[1], 32'd0);
        check("abort_req_ready", 32'(req_ready[1]), 32'd1);
        check("abort_re_count", re_total[1] - r0, 2);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        xact(1, 0, 0, 0, 20'h20, 32'h0, lat, rd, er, nre, nwe);
        check("post_abort_lat", lat, 4);
        check("post_abort_rdata", rd, 32'hCAFEF00D);
        check("post_abort_re", nre, 3);
        check("we_re_exclusive", 32'(both_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
